// File: rtl/intt16_engine.sv
// Sequential 16-point inverse NTT over Z_7681 using a single modular multiply-accumulate.
// Optional feature macro INTT_SCALE_EN adds the SCALE state that multiplies each sum by N^-1.
module intt16_engine #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_index,
    output logic              busy,
    output logic              done
);

    localparam logic [12:0] Q    = 13'd7681;
    localparam logic [12:0] NINV = 13'd7201;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
`ifdef INTT_SCALE_EN
        ST_SCALE   = 2'd2,
`endif
        ST_OUTPUT  = 2'd3
    } state_t;

    function automatic logic [12:0] mod_in(input logic [DATA_W-1:0] x);
        return 13'(x % DATA_W'(7681));
    endfunction

    function automatic logic [12:0] mod_prod(input logic [25:0] x);
        return 13'(x % 26'd7681);
    endfunction

    function automatic logic [12:0] add_mod(input logic [12:0] a, input logic [12:0] b);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, Q}) ? 13'(s - {1'b0, Q}) : s[12:0];
    endfunction

    // w^-m for the order-16 root 7098
    function automatic logic [12:0] winv(input logic [3:0] m);
        case (m)
            4'd0:    return 13'd1;
            4'd1:    return 13'd7154;
            4'd2:    return 13'd1213;
            4'd3:    return 13'd5953;
            4'd4:    return 13'd4298;
            4'd5:    return 13'd849;
            4'd6:    return 13'd5756;
            4'd7:    return 13'd583;
            4'd8:    return 13'd7680;
            4'd9:    return 13'd527;
            4'd10:   return 13'd6468;
            4'd11:   return 13'd1728;
            4'd12:   return 13'd3383;
            4'd13:   return 13'd6832;
            4'd14:   return 13'd1925;
            4'd15:   return 13'd7098;
            default: return 13'd0;
        endcase
    endfunction

    state_t      r_state, w_state_next;
    logic [12:0] r_buf [16];
    logic [3:0]  r_k, r_j;
    logic [12:0] r_acc;
    logic [12:0] r_out_data;
    logic [3:0]  r_out_index;
    logic        r_in_ready, r_out_valid, r_busy, r_done;
    logic        w_in_ready_next, w_out_valid_next, w_busy_next, w_done_next;
    logic        w_in_acc, w_out_acc;
    logic [3:0]  w_tw_idx;
    logic [25:0] w_prod;
    logic [12:0] w_acc_next;
`ifdef INTT_SCALE_EN
    logic [12:0] w_scaled;
    assign w_scaled = mod_prod(26'(r_acc) * 26'(NINV));
`endif

    assign w_in_acc   = in_valid & r_in_ready & (r_state == ST_LOAD);
    assign w_out_acc  = r_out_valid & out_ready & (r_state == ST_OUTPUT);
    // (j*k) mod 16 falls out of the 4-bit truncated product
    assign w_tw_idx   = r_j * r_k;
    assign w_prod     = 26'(r_buf[r_k]) * 26'(winv(w_tw_idx));
    assign w_acc_next = add_mod(r_acc, mod_prod(w_prod));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_LOAD;
        else      r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_in_acc && (r_k == 4'd15)) w_state_next = ST_COMPUTE;
                else                            w_state_next = ST_LOAD;
            end
            ST_COMPUTE: begin
`ifdef INTT_SCALE_EN
                if (r_k == 4'd15) w_state_next = ST_SCALE;
`else
                if (r_k == 4'd15) w_state_next = ST_OUTPUT;
`endif
                else              w_state_next = ST_COMPUTE;
            end
`ifdef INTT_SCALE_EN
            ST_SCALE: w_state_next = ST_OUTPUT;
`endif
            ST_OUTPUT: begin
                if (w_out_acc) w_state_next = (r_j == 4'd15) ? ST_LOAD : ST_COMPUTE;
                else           w_state_next = ST_OUTPUT;
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    // Output decode, registered below so every status port comes from a flop
    always_comb begin
        w_in_ready_next  = (w_state_next == ST_LOAD);
        w_out_valid_next = (w_state_next == ST_OUTPUT);
        w_busy_next      = (w_state_next != ST_LOAD);
        w_done_next      = w_out_acc && (r_j == 4'd15);
    end

    // Status output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_next;
            r_out_valid <= w_out_valid_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    // Coefficient buffer, indices, accumulator and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) r_buf[i] <= 13'd0;
            r_k         <= 4'd0;
            r_j         <= 4'd0;
            r_acc       <= 13'd0;
            r_out_data  <= 13'd0;
            r_out_index <= 4'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_acc) begin
                        r_buf[r_k] <= mod_in(in_data);
                        r_k        <= r_k + 4'd1;
                        if (r_k == 4'd15) begin
                            r_j   <= 4'd0;
                            r_acc <= 13'd0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 4'd1;
`ifndef INTT_SCALE_EN
                    if (r_k == 4'd15) begin
                        r_out_data  <= w_acc_next;
                        r_out_index <= r_j;
                    end
`endif
                end
`ifdef INTT_SCALE_EN
                ST_SCALE: begin
                    r_out_data  <= w_scaled;
                    r_out_index <= r_j;
                end
`endif
                ST_OUTPUT: begin
                    if (w_out_acc) begin
                        r_acc <= 13'd0;
                        if (r_j != 4'd15) r_j <= r_j + 4'd1;
                    end
                end
                default: r_k <= 4'd0;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = {{(DATA_W-13){1'b0}}, r_out_data};
    assign out_index = r_out_index;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
